// File: rtl/pattern_serializer_if.sv
// Word handshake between a word source and the pattern serializer.
interface pattern_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pattern_serializer.sv
// Parallel-to-serial transmitter, MSB first, with reference 001/111 match
// flags and saturating match counters for checking a downstream detector.
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | no word in flight, serial line quiet
// S_SHIFT | word in flight, idx_q is the bit now on o
module pattern_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pattern_serializer_if.slave  bus,
  output logic                 o,
  output logic                 o_valid,
  output logic [1:0]           exp,
  output logic [7:0]           cnt_001,
  output logic [7:0]           cnt_111
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       hist_q, hist_d;
  logic [1:0]       hlen_q, hlen_d;
  logic [7:0]       cnt_001_q, cnt_001_d;
  logic [7:0]       cnt_111_q, cnt_111_d;

  logic             last_bit;
  logic             xfer;
  logic             ready;

  assign last_bit = (state_q == S_SHIFT) && (idx_q == IDX_LAST);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: a reload on the last bit keeps the stream gapless
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = xfer ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake, serial line and match flags
  always_comb begin
    ready   = (state_q == S_IDLE) || last_bit;
    xfer    = bus.valid && ready;
    o_valid = (state_q == S_SHIFT);
    o       = o_valid && sreg_q[WIDTH-1];
    exp[1]  = o_valid && (hlen_q == 2'd2) && (hist_q == 2'b00) && o;
    exp[0]  = o_valid && (hlen_q == 2'd2) && (hist_q == 2'b11) && o;
  end

  assign bus.ready = ready;
  assign cnt_001   = cnt_001_q;
  assign cnt_111   = cnt_111_q;

  // Datapath next values: shifter, bit index, match history, counters
  always_comb begin
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    hlen_d    = hlen_q;
    cnt_001_d = cnt_001_q;
    cnt_111_d = cnt_111_q;

    if (xfer) begin
      sreg_d = bus.data;
      idx_d  = '0;
    end else if (state_q == S_SHIFT) begin
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      idx_d  = idx_q + 1'b1;
    end

    // A stream break wipes history so no match spans the gap
    if (state_q == S_SHIFT && state_d == S_IDLE) begin
      hist_d = 2'b00;
      hlen_d = 2'd0;
    end else if (o_valid) begin
      hist_d = {hist_q[0], o};
      hlen_d = (hlen_q == 2'd2) ? 2'd2 : hlen_q + 2'd1;
    end

    if (exp[1] && cnt_001_q != 8'hFF) cnt_001_d = cnt_001_q + 8'd1;
    if (exp[0] && cnt_111_q != 8'hFF) cnt_111_d = cnt_111_q + 8'd1;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q    <= '0;
      idx_q     <= '0;
      hist_q    <= 2'b00;
      hlen_q    <= 2'd0;
      cnt_001_q <= 8'd0;
      cnt_111_q <= 8'd0;
    end else begin
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      hist_q    <= hist_d;
      hlen_q    <= hlen_d;
      cnt_001_q <= cnt_001_d;
      cnt_111_q <= cnt_111_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed and random stimulus for pattern_serializer, checked against a
// bit-queue reference model of the serial stream.
module tb_pattern_serializer;

  localparam int W = 8;

  logic       clock;
  logic       reset_n;
  logic       o;
  logic       o_valid;
  logic [1:0] exp;
  logic [7:0] cnt_001;
  logic [7:0] cnt_111;

  pattern_serializer_if #(.WIDTH(W)) bus_if ();

  pattern_serializer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if),
    .o       (o),
    .o_valid (o_valid),
    .exp     (exp),
    .cnt_001 (cnt_001),
    .cnt_111 (cnt_111)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: bits still to be sent, last bits of the current
  // contiguous run, and the two match counts.
  bit q[$];
  bit run[$];
  int m001 = 0;
  int m111 = 0;
  bit last_xfer;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    q.delete();
    run.delete();
    m001 = 0;
    m111 = 0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit v, input logic [W-1:0] d);
    bit em, oe, e1, e0, rdy;
    int n;
    em  = (q.size() > 0);
    oe  = em ? q[0] : 1'b0;
    n   = run.size();
    e1  = em && n >= 2 && run[n-2] == 1'b0 && run[n-1] == 1'b0 && oe;
    e0  = em && n >= 2 && run[n-2] == 1'b1 && run[n-1] == 1'b1 && oe;
    rdy = (q.size() <= 1);

    bus_if.valid = v;
    bus_if.data  = d;
    #1;
    chk("ready",   int'(bus_if.ready), int'(rdy));
    chk("o",       int'(o),            int'(oe));
    chk("o_valid", int'(o_valid),      int'(em));
    chk("exp",     int'(exp),          int'({e1, e0}));
    chk("cnt_001", int'(cnt_001),      m001);
    chk("cnt_111", int'(cnt_111),      m111);

    @(posedge clock);
    last_xfer = v && rdy;
    if (em) begin
      void'(q.pop_front());
      run.push_back(oe);
      if (run.size() > 2) void'(run.pop_front());
      if (e1 && m001 < 255) m001++;
      if (e0 && m111 < 255) m111++;
    end else begin
      run.delete();
    end
    if (last_xfer)
      for (int j = W - 1; j >= 0; j--) q.push_back(d[j]);
    @(negedge clock);
  endtask

  task automatic send(input logic [W-1:0] d);
    do cycle(1'b1, d); while (!last_xfer);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom));
  endtask

  // Assert reset at a falling edge; outputs must drop immediately.
  task automatic apply_reset();
    bus_if.valid = 1'b0;
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("rst_o",       int'(o),            0);
    chk("rst_o_valid", int'(o_valid),      0);
    chk("rst_exp",     int'(exp),          0);
    chk("rst_ready",   int'(bus_if.ready), 1);
    chk("rst_cnt_001", int'(cnt_001),      0);
    chk("rst_cnt_111", int'(cnt_111),      0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    bit            have;
    logic [W-1:0]  word;

    reset_n      = 1'b0;
    bus_if.valid = 1'b0;
    bus_if.data  = '0;
    @(negedge clock);

    // Reset then 20 quiet cycles
    apply_reset();
    idle(20);

    // Single word B1
    send(8'hB1);
    idle(10);
    chk("b1_cnt_001", int'(cnt_001), 1);
    chk("b1_cnt_111", int'(cnt_111), 0);

    // Back-to-back FF then 00
    apply_reset();
    send(8'hFF);
    send(8'h00);
    idle(10);
    chk("ff00_cnt_111", int'(cnt_111), 6);
    chk("ff00_cnt_001", int'(cnt_001), 0);

    // A gap between 00 and 80 breaks the history
    apply_reset();
    send(8'h00);
    idle(10);
    send(8'h80);
    idle(10);
    chk("gap_cnt_001", int'(cnt_001), 0);

    // Reset four bits into FF, then 07
    apply_reset();
    send(8'hFF);
    idle(4);
    apply_reset();
    send(8'h07);
    idle(10);
    chk("rst07_cnt_001", int'(cnt_001), 1);
    chk("rst07_cnt_111", int'(cnt_111), 1);

    // Saturation with 86 back-to-back FF words
    apply_reset();
    for (int k = 0; k < 86; k++) send(8'hFF);
    idle(10);
    chk("sat_cnt_111", int'(cnt_111), 255);
    chk("sat_cnt_001", int'(cnt_001), 0);

    // Random words with random gaps; a word is held until accepted
    apply_reset();
    have = 1'b0;
    word = '0;
    for (int i = 0; i < 600; i++) begin
      if (!have) begin
        have = ($urandom_range(0, 3) != 0);
        word = W'($urandom);
        if ($urandom_range(0, 1) == 1) word = word & W'($urandom);
      end
      cycle(have, have ? word : W'($urandom));
      if (last_xfer) have = 1'b0;
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
